// File: rtl/cfir_win_if.sv
// cfir_win_if: valid/ready handshake bundle for the 6-tap window builder.
// Carries the input pixel beat, the output tap window with its flags, and err_sol.
interface cfir_win_if #(
    parameter int PIX_W = 8
);
    logic [PIX_W-1:0] in_pix;
    logic             in_valid;
    logic             in_sol;
    logic             in_eol;
    logic             in_ready;
    logic [PIX_W-1:0] out_a;
    logic [PIX_W-1:0] out_b;
    logic [PIX_W-1:0] out_c;
    logic [PIX_W-1:0] out_d;
    logic [PIX_W-1:0] out_e;
    logic [PIX_W-1:0] out_f;
    logic             out_valid;
    logic             out_ready;
    logic             out_sol;
    logic             out_eol;
    logic             err_sol;

    modport master (
        output in_pix, in_valid, in_sol, in_eol, out_ready,
        input  in_ready, out_a, out_b, out_c, out_d, out_e, out_f,
        input  out_valid, out_sol, out_eol, err_sol
    );

    modport slave (
        input  in_pix, in_valid, in_sol, in_eol, out_ready,
        output in_ready, out_a, out_b, out_c, out_d, out_e, out_f,
        output out_valid, out_sol, out_eol, err_sol
    );
endinterface

// File: rtl/cfir_win.sv
// cfir_win: builds 6-pixel windows (x-2..x+3) from a raster stream, with edge padding.
// Ports: clk, rst (async high), bus (cfir_win_if.slave): in_* beat, out_a..f window, flags.
// Option CFIR_WIN_ZERO_PAD_EN: pad line edges with zero instead of replicating.
module cfir_win #(
    parameter int PIX_W = 8,
    parameter int CNT_W = 12
) (
    input  logic         clk,
    input  logic         rst,
    cfir_win_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    localparam logic [CNT_W-1:0] WMAX = CNT_W'((1 << CNT_W) - 3);

    state_t           r_state;
    logic [PIX_W-1:0] r_tap [6];
    logic [CNT_W-1:0] r_sc;
    logic [CNT_W-1:0] r_wlen;
    logic             r_valid;
    logic             r_sol;
    logic             r_eol;
    logic             r_err;

    logic             w_adv;
    logic [PIX_W-1:0] w_pad_sol;
    logic [PIX_W-1:0] w_pad_fl;
    logic [CNT_W-1:0] w_sc_nx;
    logic [CNT_W-1:0] w_wlen_nx;

    assign w_adv     = !r_valid || bus.out_ready;
    assign w_sc_nx   = r_sc + 1'b1;
    assign w_wlen_nx = r_wlen + 1'b1;

`ifdef CFIR_WIN_ZERO_PAD_EN
    assign w_pad_sol = '0;
    assign w_pad_fl  = '0;
`else
    assign w_pad_sol = bus.in_pix;
    assign w_pad_fl  = r_tap[5];
`endif

    assign bus.in_ready  = w_adv && (r_state != FLUSH);
    assign bus.out_a     = r_tap[0];
    assign bus.out_b     = r_tap[1];
    assign bus.out_c     = r_tap[2];
    assign bus.out_d     = r_tap[3];
    assign bus.out_e     = r_tap[4];
    assign bus.out_f     = r_tap[5];
    assign bus.out_valid = r_valid;
    assign bus.out_sol   = r_sol;
    assign bus.out_eol   = r_eol;
    assign bus.err_sol   = r_err;

    // The sol beat lands in f with the padding ahead of it, so three more
    // shifts (sc==3) bring p0 to c and the first window is complete.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            for (int i = 0; i < 6; i++) r_tap[i] <= '0;
            r_sc    <= '0;
            r_wlen  <= '0;
            r_valid <= 1'b0;
            r_sol   <= 1'b0;
            r_eol   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (w_adv) begin
                r_valid <= 1'b0;
                r_sol   <= 1'b0;
                r_eol   <= 1'b0;
                unique case (r_state)
                    IDLE, RUN: begin
                        if (bus.in_valid && bus.in_sol) begin
                            r_err <= (r_state == RUN);
                            for (int i = 0; i < 5; i++) r_tap[i] <= w_pad_sol;
                            r_tap[5] <= bus.in_pix;
                            r_sc     <= '0;
                            r_wlen   <= CNT_W'(1);
                            r_state  <= bus.in_eol ? FLUSH : RUN;
                        end else if (bus.in_valid && r_state == RUN) begin
                            for (int i = 0; i < 5; i++) r_tap[i] <= r_tap[i+1];
                            r_tap[5] <= bus.in_pix;
                            r_sc     <= w_sc_nx;
                            r_wlen   <= w_wlen_nx;
                            if (bus.in_eol || w_wlen_nx == WMAX) r_state <= FLUSH;
                            if (w_sc_nx >= CNT_W'(3)) begin
                                r_valid <= 1'b1;
                                r_sol   <= (w_sc_nx == CNT_W'(3));
                            end
                        end
                    end
                    FLUSH: begin
                        for (int i = 0; i < 5; i++) r_tap[i] <= r_tap[i+1];
                        r_tap[5] <= w_pad_fl;
                        r_sc     <= w_sc_nx;
                        if (w_sc_nx >= CNT_W'(3)) begin
                            r_valid <= 1'b1;
                            r_sol   <= (w_sc_nx == CNT_W'(3));
                            r_eol   <= (w_sc_nx == r_wlen + CNT_W'(2));
                        end
                        if (w_sc_nx == r_wlen + CNT_W'(2)) r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cfir_win.sv
// tb_cfir_win: directed-vector bench for cfir_win.
// Captures handshaked windows and checks them against hand/edge-model values.
module tb_cfir_win;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_errsol = 0;
    bit   tog_en = 1'b0;
    int   tog_i = 0;
    logic [49:0] cap[$];
    logic [49:0] held;
    bit   stall = 1'b0;

    cfir_win_if bus ();
    cfir_win dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [49:0] cur_win();
        return {bus.out_sol, bus.out_eol, bus.out_a, bus.out_b,
                bus.out_c, bus.out_d, bus.out_e, bus.out_f};
    endfunction

    // Monitor: capture accepted windows, check hold while stalled, count err pulses.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (stall) chk("hold", 64'(cur_win()), 64'(held));
            stall = bus.out_valid && !bus.out_ready;
            held  = cur_win();
            if (bus.out_valid && bus.out_ready) cap.push_back(cur_win());
            if (bus.err_sol) n_errsol++;
        end else begin
            stall = 1'b0;
        end
    end

    // Downstream ready pattern 1,0,0,1 when enabled.
    initial forever begin
        @(posedge clk);
        #1;
        if (tog_en) begin
            bus.out_ready = (tog_i % 4 == 0) || (tog_i % 4 == 3);
            tog_i++;
        end
    end

    function automatic logic [49:0] exp_win(input int px[8], input int w, input int k);
        logic [47:0] t = '0;
        int v;
        for (int j = 0; j < 6; j++) begin
            int idx = k - 2 + j;
`ifdef CFIR_WIN_ZERO_PAD_EN
            if (idx < 0 || idx >= w) v = 0;
            else v = px[idx];
`else
            if (idx < 0) v = px[0];
            else if (idx >= w) v = px[w-1];
            else v = px[idx];
`endif
            t = {t[39:0], 8'(v)};
        end
        return {k == 0, k == w - 1, t};
    endfunction

    task automatic send(input logic [7:0] p, input bit s, input bit e);
        bit acc = 1'b0;
        int n = 0;
        bus.in_pix = p;
        bus.in_valid = 1'b1;
        bus.in_sol = s;
        bus.in_eol = e;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
        bus.in_sol = 1'b0;
        bus.in_eol = 1'b0;
        if (!acc) chk("send_timeout", 64'(acc), 64'(1));
    endtask

    task automatic send_line(input int px[8], input int w);
        for (int i = 0; i < w; i++) send(8'(px[i]), i == 0, i == w - 1);
    endtask

    task automatic drain();
        repeat (14) @(posedge clk);
        #1;
    endtask

    task automatic check_line(input string tag, input int px[8], input int w);
        chk({tag, "_count"}, 64'(cap.size()), 64'(w));
        for (int k = 0; k < w && k < cap.size(); k++)
            chk($sformatf("%s_w%0d", tag, k), 64'(cap[k]), 64'(exp_win(px, w, k)));
    endtask

    int px6[8]  = '{10, 20, 30, 40, 50, 60, 0, 0};
    int px1[8]  = '{77, 0, 0, 0, 0, 0, 0, 0};
    int px4[8]  = '{10, 20, 30, 40, 0, 0, 0, 0};
    int pxm[8]  = '{9, 10, 11, 12, 0, 0, 0, 0};
    logic [49:0] first6, last6;

    initial begin
        bus.in_pix = '0;
        bus.in_valid = 1'b0;
        bus.in_sol = 1'b0;
        bus.in_eol = 1'b0;
        bus.out_ready = 1'b1;
        #12;
        chk("rst_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_errsol", 64'(bus.err_sol), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ready", 64'(bus.in_ready), 64'(1));

`ifdef CFIR_WIN_ZERO_PAD_EN
        first6 = {1'b1, 1'b0, 8'd0, 8'd0, 8'd10, 8'd20, 8'd30, 8'd40};
        last6  = {1'b0, 1'b1, 8'd40, 8'd50, 8'd60, 8'd0, 8'd0, 8'd0};
`else
        first6 = {1'b1, 1'b0, 8'd10, 8'd10, 8'd10, 8'd20, 8'd30, 8'd40};
        last6  = {1'b0, 1'b1, 8'd40, 8'd50, 8'd60, 8'd60, 8'd60, 8'd60};
`endif

        // Six-pixel line, free-running downstream.
        cap.delete();
        send_line(px6, 6);
        drain();
        check_line("l6", px6, 6);
        if (cap.size() == 6) begin
            chk("l6_first", 64'(cap[0]), 64'(first6));
            chk("l6_last", 64'(cap[5]), 64'(last6));
        end

        // Single pixel line with sol+eol: three flush cycles with in_ready low.
        cap.delete();
        send(8'd77, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("w1_ready%0d", i), 64'(bus.in_ready), 64'(0));
        end
        @(negedge clk);
        chk("w1_ready_back", 64'(bus.in_ready), 64'(1));
        drain();
        check_line("w1", px1, 1);

        // Same six-pixel line with downstream stalling.
        cap.delete();
        tog_i = 0;
        tog_en = 1'b1;
        send_line(px6, 6);
        repeat (30) @(posedge clk);
        tog_en = 1'b0;
        #2;
        bus.out_ready = 1'b1;
        drain();
        check_line("tog", px6, 6);

        // Mid-line sol abandons the first line.
        cap.delete();
        n_errsol = 0;
        send(8'd1, 1'b1, 1'b0);
        send(8'd2, 1'b0, 1'b0);
        send(8'd3, 1'b0, 1'b0);
        send(8'd9, 1'b1, 1'b0);
        send(8'd10, 1'b0, 1'b0);
        send(8'd11, 1'b0, 1'b0);
        send(8'd12, 1'b0, 1'b1);
        drain();
        chk("mid_errsol", 64'(n_errsol), 64'(1));
        check_line("mid", pxm, 4);

        // Async reset while flushing.
        send_line(px4, 4);
        @(posedge clk);
        #1;
        chk("fl_valid_pre", 64'(bus.out_valid), 64'(1));
        rst = 1'b1;
        #1;
        chk("fl_valid_rst", 64'(bus.out_valid), 64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("fl_ready_idle", 64'(bus.in_ready), 64'(1));
        cap.delete();
        send_line(px6, 6);
        drain();
        check_line("post", px6, 6);

        // Four-pixel line.
        cap.delete();
        send_line(px4, 4);
        drain();
        check_line("l4", px4, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
